// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind a UART receiver, with occupancy flags and sticky overflow
module uart_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  input  logic              ovf_clr
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop;
  assign empty       = count == '0;
  assign full        = count == (ADDR_W+1)'(DEPTH);
  assign almost_full = count >= (ADDR_W+1)'(AF_LEVEL);
  assign rd_valid    = !empty;
  assign rd_data     = empty ? '0 : mem[rd_ptr];
  assign pop         = rd_valid & rd_ready;
  assign push        = wr_en & (!full | pop);
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
      overflow <= (wr_en & full & !pop) | (overflow & !ovf_clr);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-model scoreboard bench with directed scenarios and random traffic
module tb_uart_rx_fifo;
  logic       clk = 0, rst = 1, wr_en = 0, rd_ready = 0, ovf_clr = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic       rd_valid, empty, full, almost_full, overflow;
  logic [4:0] count;
  int         tests = 0, fails = 0, occ = 0;
  bit         ovf_m = 0;
  logic [7:0] sb[$];

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .count(count), .empty(empty),
    .full(full), .almost_full(almost_full), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_underflow: got byte %0h expected no byte at %0t", rd_data, $time);
      end else chk("pop_data", rd_data, sb.pop_front());
    end

  task automatic check_state();
    chk("count", count, occ);
    chk("empty", empty, occ == 0);
    chk("full", full, occ == 16);
    chk("almost_full", almost_full, occ >= 12);
    chk("rd_valid", rd_valid, occ > 0);
    chk("overflow", overflow, ovf_m);
    chk("head", rd_data, occ > 0 ? sb[0] : 8'h00);
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit rr, input bit clr);
    bit p, q, drop;
    wr_en = we; wr_data = wd; rd_ready = rr; ovf_clr = clr;
    p = rr && occ > 0;
    q = we && (occ < 16 || p);
    drop = we && occ == 16 && !p;
    @(posedge clk); #1;
    if (q) sb.push_back(wd);
    occ = occ + int'(q) - int'(p);
    ovf_m = drop | (ovf_m & !clr);
    check_state();
  endtask

  task automatic do_reset();
    rst = 1; wr_en = 1; wr_data = 8'h77; rd_ready = 1; ovf_clr = 0;
    @(posedge clk); #1;
    rst = 0; wr_en = 0; rd_ready = 0;
    sb.delete(); occ = 0; ovf_m = 0;
    check_state();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1, 0);
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    do_reset();
    foreach (sb[i]) ;
    step(1, 8'h41, 0, 0); step(1, 8'h42, 0, 0); step(1, 8'h43, 0, 0);
    chk("t1_head", rd_data, 8'h41);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    chk("t1_empty_data", rd_data, 8'h00);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    chk("t2_overflow", overflow, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0);
    step(1, 8'hAA, 1, 0);
    chk("t3_count", count, 5'd16);
    chk("t3_last", sb[15], 8'hAA);
    drain();
    do_reset();
    step(1, 8'h00, 0, 0);
    for (int i = 1; i < 40; i++) step(1, 8'(i), 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0);
    do_reset();
    step(1, 8'h5A, 0, 0);
    chk("t5_first", rd_data, 8'h5A);
    drain();
    for (int i = 0; i < 16; i++) step(1, 8'(8'hC0 + i), 0, 0);
    step(1, 8'hFF, 0, 1);
    chk("t6_set_wins", overflow, 1'b1);
    step(0, 8'h00, 0, 1);
    chk("t6_cleared", overflow, 1'b0);
    drain();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0 ? 1'b1 : (i % 100 > 50),
           $urandom_range(0, 15) == 0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
